pow_fixed: RTL and testbench

- Iterative fixed-point power unit; the inverse of the n-th root engine.
- Takes a Q10.10 unsigned value x and an exponent n in 0..7, and returns x^n as Q10.10. Results above the Q10.10 range saturate.
- Uses the same in_valid burst / single-cycle out_valid handshake as the root engine. It sits beside that engine so root results can be raised back to the n-th power for self-check.

---
 rtl/pow_fixed.sv | 78 +++++++
 tb/tb_pow_fixed.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pow_fixed.sv
// pow_fixed: iterative Q10.10 x^n (n in 0..7), saturating; ports clk, rst_n (sync, active-low), in_valid/in_data_1 (x)/in_data_2 (n) in, out_valid/out_data/out_sat out; define POW_ROUND_EN for round-half-up instead of truncation
module pow_fixed #(
  parameter int FRAC_W = 10,
  parameter int EXP_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [2*FRAC_W-1:0]   in_data_1,
  input  logic [EXP_W-1:0]      in_data_2,
  output logic                  out_valid,
  output logic [2*FRAC_W-1:0]   out_data,
  output logic                  out_sat
);
  localparam int DW    = 2 * FRAC_W;
  localparam int ACC_W = DW * (2**EXP_W - 1);
  localparam int SH_W  = $clog2(ACC_W);
  typedef enum logic [1:0] {ST_IDLE, ST_STORE, ST_COMPUTE, ST_OUTPUT} state_t;
  state_t state, state_nx;
  logic [DW-1:0]    x_reg;
  logic [EXP_W-1:0] n_reg, cnt;
  logic [ACC_W-1:0] acc;
  logic [SH_W-1:0]  sh;
  logic [ACC_W:0]   sum, q;
  logic             sat, done;
  always_ff @(posedge clk)
    state <= !rst_n ? ST_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    state_nx = in_valid ? ST_STORE : ST_IDLE;
      ST_STORE:   state_nx = in_valid ? ST_STORE : ST_COMPUTE;
      ST_COMPUTE: state_nx = done ? ST_OUTPUT : ST_COMPUTE;
      default:    state_nx = ST_IDLE;
    endcase
  end
  assign done = state == ST_COMPUTE && cnt == n_reg;
  // acc carries 10n fraction bits; drop 10(n-1) of them to get back to Q10.10
  always_comb begin
    sh = SH_W'(FRAC_W * (int'(n_reg) - 1));
`ifdef POW_ROUND_EN
    sum = {1'b0, acc} + ((n_reg >= EXP_W'(2)) ? ((ACC_W+1)'(1) << (sh - SH_W'(1))) : '0);
`else
    sum = {1'b0, acc};
`endif
    q = (n_reg == '0) ? ((ACC_W+1)'(1) << FRAC_W) : (sum >> sh);
    sat = |q[ACC_W:DW];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_reg     <= '0;
      n_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if ((state == ST_IDLE || state == ST_STORE) && in_valid) begin
        x_reg <= in_data_1;
        n_reg <= in_data_2;
      end
      if (state == ST_STORE && !in_valid) begin
        acc <= ACC_W'(1);
        cnt <= '0;
      end
      if (state == ST_COMPUTE && !done) begin
        acc <= acc * ACC_W'(x_reg);
        cnt <= cnt + EXP_W'(1);
      end
      out_valid <= done;
      if (done) begin
        out_data <= sat ? '1 : q[DW-1:0];
        out_sat  <= sat;
      end
    end
  end
endmodule

// File: tb/tb_pow_fixed.sv
// tb_pow_fixed: randomized and directed checks of pow_fixed against an arithmetic model
module tb_pow_fixed;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic [19:0] in_data_1 = 0;
  logic [2:0]  in_data_2 = 0;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_sat;
  int n_chk = 0, n_pass = 0;
  pow_fixed dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data_1(in_data_1),
    .in_data_2(in_data_2), .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // exact x^n / 1024^(n-1), floored (or rounded half-up), then clipped to 20 bits
  function automatic logic [20:0] model(input logic [19:0] x, input int n);
    logic [159:0] p, d;
    p = 1;
    d = 1;
    if (n == 0) return {1'b0, 20'h00400};
    for (int i = 0; i < n; i++) p = p * 160'(x);
    for (int i = 1; i < n; i++) d = d * 160'd1024;
`ifdef POW_ROUND_EN
    if (n >= 2) p = p + d / 160'd2;
`endif
    p = p / d;
    return (p > 160'hFFFFF) ? {1'b1, 20'hFFFFF} : {1'b0, p[19:0]};
  endfunction
  // beats-1 junk beats precede the real one; noise pokes in_valid during COMPUTE
  task automatic xact(input string tag, input logic [19:0] x, input logic [2:0] n,
                      input int beats, input bit noise, input logic [20:0] exp);
    int cyc;
    for (int b = 1; b < beats; b++) begin
      @(negedge clk);
      in_valid = 1;
      in_data_1 = 20'($urandom);
      in_data_2 = 3'($urandom);
    end
    @(negedge clk);
    in_valid = 1;
    in_data_1 = x;
    in_data_2 = n;
    @(negedge clk);
    in_valid = 0;
    cyc = 0;
    while (cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
      if (noise && n != 0 && cyc == 1) begin
        in_valid = 1;
        in_data_1 = 20'hFFFFF;
        in_data_2 = 3'd7;
      end else if (cyc == 2) in_valid = 0;
    end
    in_valid = 0;
    chk({tag, " latency"}, 32'(cyc - 1), 32'(n) + 1);
    chk({tag, " data"}, 32'(out_data), 32'(exp[19:0]));
    chk({tag, " sat"}, 32'(out_sat), 32'(exp[20]));
    @(posedge clk);
    #1;
    chk({tag, " pulse"}, 32'(out_valid), 0);
  endtask
  initial begin
    logic [19:0] rx;
    logic [2:0]  rn;
    int          seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 32'(out_valid), 0);
    chk("reset data", 32'(out_data), 0);
    chk("reset sat", 32'(out_sat), 0);
    @(negedge clk);
    rst_n = 1;
    xact("two_cubed", 20'h00800, 3'd3, 1, 0, {1'b0, 20'h02000});
    xact("last_beat", 20'h00600, 3'd2, 3, 0, {1'b0, 20'h00900});
    xact("n0", 20'h12345, 3'd0, 1, 0, {1'b0, 20'h00400});
    xact("n1", 20'h12345, 3'd1, 1, 0, {1'b0, 20'h12345});
    xact("sat", 20'hFFFFF, 3'd2, 1, 0, {1'b1, 20'hFFFFF});
    xact("one_pow7", 20'h00400, 3'd7, 1, 0, {1'b0, 20'h00400});
    xact("zero_n3", 20'h00000, 3'd3, 1, 0, {1'b0, 20'h00000});
    xact("zero_n0", 20'h00000, 3'd0, 2, 0, {1'b0, 20'h00400});
`ifdef POW_ROUND_EN
    xact("half_lsb", 20'h005A8, 3'd2, 1, 0, {1'b0, 20'h00800});
`else
    xact("half_lsb", 20'h005A8, 3'd2, 1, 0, {1'b0, 20'h007FF});
`endif
    xact("noise_ign", 20'h00800, 3'd3, 1, 1, {1'b0, 20'h02000});
    @(negedge clk);
    in_valid = 1;
    in_data_1 = 20'h00800;
    in_data_2 = 3'd7;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst valid", 32'(out_valid), 0);
    chk("mid_rst data", 32'(out_data), 0);
    chk("mid_rst sat", 32'(out_sat), 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mid_rst no_pulse", 32'(seen), 0);
    xact("after_rst", 20'h00800, 3'd3, 1, 0, {1'b0, 20'h02000});
    for (int i = 0; i < 40; i++) begin
      rx = 20'($urandom) >> $urandom_range(0, 19);
      rn = 3'($urandom_range(0, 7));
      xact("rand", rx, rn, int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)), model(rx, int'(rn)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
